// File: rtl/mlcd_8080_ctrl.sv
// mlcd_8080_ctrl: 8080-style LCD bus engine with power-on reset and fill writes; read path under MLCD_READ_EN
module mlcd_8080_ctrl #(
  parameter int unsigned T_SETUP      = 1,
  parameter int unsigned T_WRL        = 2,
  parameter int unsigned T_WRH        = 2,
  parameter int unsigned T_RDL        = 20,
  parameter int unsigned T_RDH        = 5,
  parameter int unsigned RST_LOW_CYC  = 500000,
  parameter int unsigned RST_WAIT_CYC = 6000000,
  parameter int          REP_W        = 17
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_rs,
  input  logic             cmd_rd,
  input  logic [15:0]      cmd_data,
  input  logic [REP_W-1:0] cmd_rep,
  input  logic             bl_en,
  output logic             busy,
  output logic [15:0]      rd_data,
  output logic             rd_valid,
  inout  wire  [15:0]      mlcd_data,
  output logic             mlcd_cs_n,
  output logic             mlcd_wr_n,
  output logic             mlcd_rd_n,
  output logic             mlcd_rs,
  output logic             mlcd_rst_n,
  output logic             mlcd_bl
);
`ifdef MLCD_READ_EN
  localparam logic RD_EN = 1'b1;
`else
  localparam logic RD_EN = 1'b0;
`endif
  typedef enum logic [2:0] {RST_LOW, RST_WAIT, IDLE, SETUP, WR_LOW, WR_HIGH, RD_LOW, RD_HIGH} state_t;
  state_t           state;
  logic [31:0]      cnt;
  logic [31:0]      lim;
  logic             last;
  logic [REP_W-1:0] rep;
  logic             is_rd;
  logic             drv;
  logic [15:0]      dout;
  always_comb begin
    lim = state == RST_LOW  ? RST_LOW_CYC - 1 :
          state == RST_WAIT ? RST_WAIT_CYC - 1 :
          state == SETUP    ? T_SETUP - 1 :
          state == WR_LOW   ? T_WRL - 1 :
          state == WR_HIGH  ? T_WRH - 1 :
          state == RD_LOW   ? T_RDL - 1 : T_RDH - 1;
    last = cnt == lim;
  end
  assign mlcd_data = drv ? dout : 16'hzzzz;
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state      <= RST_LOW;
      cnt        <= '0;
      rep        <= '0;
      is_rd      <= 1'b0;
      drv        <= 1'b0;
      dout       <= '0;
      cmd_ready  <= 1'b0;
      busy       <= 1'b1;
      rd_data    <= '0;
      rd_valid   <= 1'b0;
      mlcd_cs_n  <= 1'b1;
      mlcd_wr_n  <= 1'b1;
      mlcd_rd_n  <= 1'b1;
      mlcd_rs    <= 1'b0;
      mlcd_rst_n <= 1'b0;
      mlcd_bl    <= 1'b0;
    end else begin
      mlcd_bl  <= bl_en;
      rd_valid <= 1'b0;
      cnt      <= (last || state == IDLE) ? '0 : cnt + 32'd1;
      case (state)
        RST_LOW: if (last) begin
          mlcd_rst_n <= 1'b1;
          state      <= RST_WAIT;
        end
        RST_WAIT: if (last) begin
          state     <= IDLE;
          cmd_ready <= 1'b1;
          busy      <= 1'b0;
        end
        IDLE: if (cmd_valid) begin
          state     <= SETUP;
          cmd_ready <= 1'b0;
          busy      <= 1'b1;
          mlcd_cs_n <= 1'b0;
          mlcd_rs   <= cmd_rs;
          rep       <= cmd_rep;
          is_rd     <= RD_EN & cmd_rd;
          drv       <= !(RD_EN & cmd_rd);
          dout      <= cmd_data;
        end
        SETUP: if (last) begin
          state     <= is_rd ? RD_LOW : WR_LOW;
          mlcd_wr_n <= is_rd;
          mlcd_rd_n <= !is_rd;
        end
        WR_LOW: if (last) begin
          mlcd_wr_n <= 1'b1;
          state     <= WR_HIGH;
        end
        WR_HIGH: if (last) begin
          if (rep != '0) begin
            rep       <= rep - 1'b1;
            mlcd_wr_n <= 1'b0;
            state     <= WR_LOW;
          end else begin
            state     <= IDLE;
            mlcd_cs_n <= 1'b1;
            drv       <= 1'b0;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
          end
        end
        RD_LOW: if (last) begin
          mlcd_rd_n <= 1'b1;
          rd_data   <= mlcd_data;
          rd_valid  <= 1'b1;
          state     <= RD_HIGH;
        end
        RD_HIGH: if (last) begin
          state     <= IDLE;
          mlcd_cs_n <= 1'b1;
          cmd_ready <= 1'b1;
          busy      <= 1'b0;
        end
      endcase
    end
  end
endmodule
